mem_port_arbiter: RTL

Shares one single-port unified memory between the instruction-fetch stage (IF port) and the data-memory-access stage (DM port) of the pipeline. It arbitrates, issues one access at a time with registered memory-side outputs, waits a fixed memory latency, and returns read data with a one-cycle acknowledge. It drives per-port stall signals so the pipeline freezes until its access completes.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               (IF) and data-memory (DM) pipeline stages. One access is in
//               flight at a time; memory-side outputs are registered, read
//               data is captured after a fixed latency and each completion is
//               signalled with a one-cycle acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;   // 1 = DM owns the access
    logic              acc_we_q, acc_we_d;       // in-flight access is a write
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            acc_we_q    <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            acc_we_q    <= acc_we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Arbitration, access sequencing and response capture
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        acc_we_d    = acc_we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        // DM has priority unless IF has been passed over STARVE_LIMIT times
        grant_dm    = dm_req && !(if_req && (starve_q == STARVE_MAX));

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    owner_dm_d = grant_dm;
                    acc_we_d   = grant_dm & dm_we;
                    mem_en_d   = 1'b1;
                    mem_we_d   = grant_dm & dm_we;
                    if (grant_dm) begin
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        mem_addr_d  = if_addr;
                    end
                    if (!if_req || !grant_dm) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (owner_dm_q) begin
                        dm_ack_d = 1'b1;
                        if (!acc_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

endmodule
`default_nettype wire
